sha2_w_expander_pipe: RTL and testbench

SHA2_W_EXPANDER_PIPE -- requirements
Module: sha2_w_expander_pipe

---
 rtl/sha2_pkg.sv | 27 ++
 rtl/sha2_w_step.sv | 35 +++
 rtl/sha2_w_expander_pipe.sv | 111 +++++++++++
 tb/tb_sha2_w_expander_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// Shared SHA-2 message-schedule constants: sigma rotate/shift amounts for both
// word widths, legal round counts and the expander state type.
package sha2_pkg;

  localparam int unsigned S0_R1_256 = 7;
  localparam int unsigned S0_R2_256 = 18;
  localparam int unsigned S0_SH_256 = 3;
  localparam int unsigned S1_R1_256 = 17;
  localparam int unsigned S1_R2_256 = 19;
  localparam int unsigned S1_SH_256 = 10;

  localparam int unsigned S0_R1_512 = 1;
  localparam int unsigned S0_R2_512 = 8;
  localparam int unsigned S0_SH_512 = 7;
  localparam int unsigned S1_R1_512 = 19;
  localparam int unsigned S1_R2_512 = 61;
  localparam int unsigned S1_SH_512 = 6;

  localparam int unsigned ROUNDS_256 = 64;
  localparam int unsigned ROUNDS_512 = 80;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

endpackage

// File: rtl/sha2_w_step.sv
// One SHA-2 schedule word: W[j] = s1(W[j-2]) + W[j-7] + s0(W[j-15]) + W[j-16].
module sha2_w_step
  import sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic [WORD_W-1:0] w_m2,
  input  logic [WORD_W-1:0] w_m7,
  input  logic [WORD_W-1:0] w_m15,
  input  logic [WORD_W-1:0] w_m16,
  output logic [WORD_W-1:0] w_new
);

  localparam int unsigned S0A = (WORD_W == 64) ? S0_R1_512 : S0_R1_256;
  localparam int unsigned S0B = (WORD_W == 64) ? S0_R2_512 : S0_R2_256;
  localparam int unsigned S0C = (WORD_W == 64) ? S0_SH_512 : S0_SH_256;
  localparam int unsigned S1A = (WORD_W == 64) ? S1_R1_512 : S1_R1_256;
  localparam int unsigned S1B = (WORD_W == 64) ? S1_R2_512 : S1_R2_256;
  localparam int unsigned S1C = (WORD_W == 64) ? S1_SH_512 : S1_SH_256;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                              input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  logic [WORD_W-1:0] s0;
  logic [WORD_W-1:0] s1;

  always_comb begin
    s0    = rotr(w_m15, S0A) ^ rotr(w_m15, S0B) ^ (w_m15 >> S0C);
    s1    = rotr(w_m2, S1A) ^ rotr(w_m2, S1B) ^ (w_m2 >> S1C);
    w_new = s1 + w_m7 + s0 + w_m16;
  end

endmodule

// File: rtl/sha2_w_expander_pipe.sv
// SHA-2 message schedule expander: accepts a 16-word block and streams
// W[0..ROUNDS-1], STEPS words per beat, over a valid/ready interface.
module sha2_w_expander_pipe
  import sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned STEPS  = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [16*WORD_W-1:0]    block_in,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [STEPS*WORD_W-1:0] w_out,
  output logic [6:0]              w_index,
  output logic                    w_last
);

  localparam logic [6:0] T_LAST = 7'(ROUNDS - STEPS);
  localparam logic [6:0] T_STEP = 7'(STEPS);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] win_d [16];
  logic [6:0]        t_q, t_d;
  logic              last_q, last_d;
  logic [WORD_W-1:0] new_w [STEPS];

  // Step k's W[j-2] comes from the window for k<2, else from step k-2 this cycle.
  for (genvar k = 0; k < STEPS; k++) begin : g_step
    logic [WORD_W-1:0] m2;
    if (k < 2) begin : g_win
      assign m2 = win_q[14+k];
    end else begin : g_chain
      assign m2 = new_w[k-2];
    end
    sha2_w_step #(.WORD_W(WORD_W)) u_step (
      .w_m2  (m2),
      .w_m7  (win_q[9+k]),
      .w_m15 (win_q[1+k]),
      .w_m16 (win_q[k]),
      .w_new (new_w[k])
    );
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    t_d     = t_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          for (int unsigned i = 0; i < 16; i++) begin
            win_d[i] = block_in[(15-i)*WORD_W +: WORD_W];
          end
          t_d     = '0;
          last_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (w_ready) begin
          if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
          end else begin
            for (int unsigned i = 0; i < 16 - STEPS; i++) begin
              win_d[i] = win_q[i+STEPS];
            end
            for (int unsigned k = 0; k < STEPS; k++) begin
              win_d[16-STEPS+k] = new_w[k];
            end
            t_d    = t_q + T_STEP;
            last_d = ((t_q + T_STEP) == T_LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      win_q   <= '{default: '0};
      t_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      t_q     <= t_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    in_ready = (state_q == IDLE) && !RST;
    w_valid  = (state_q == RUN);
    w_index  = t_q;
    w_last   = last_q;
    w_out    = '0;
    for (int unsigned k = 0; k < STEPS; k++) begin
      w_out[(STEPS-1-k)*WORD_W +: WORD_W] = win_q[k];
    end
  end

endmodule

// File: tb/tb_sha2_w_expander_pipe.sv
// Bench for sha2_w_expander_pipe: three configurations (32/1, 32/4, 64/2)
// checked against a plain-arithmetic SHA-2 schedule model.
module tb_sha2_w_expander_pipe;

  typedef logic [63:0] blk_t [16];
  typedef logic [63:0] sch_t [80];
  typedef struct {
    int          d;
    int          idx;
    logic [63:0] val;
  } vec_t;

  localparam int NW [3] = '{32, 32, 64};
  localparam int NR [3] = '{64, 64, 80};
  localparam int NS [3] = '{1, 4, 2};

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    iv, wr, ir, wv, wl;
  logic [1023:0] bus;
  logic [31:0]   wo0;
  logic [127:0]  wo1, wo2;
  logic [6:0]    wi0, wi1, wi2;

  int n_cmp = 0;
  int n_fail = 0;
  sch_t got [3];

  always #5 clk = ~clk;

  sha2_w_expander_pipe #(.WORD_W(32), .ROUNDS(64), .STEPS(1)) dut0 (
    .CLK(clk), .RST(rst), .in_valid(iv[0]), .in_ready(ir[0]), .block_in(bus[511:0]),
    .w_valid(wv[0]), .w_ready(wr[0]), .w_out(wo0), .w_index(wi0), .w_last(wl[0]));
  sha2_w_expander_pipe #(.WORD_W(32), .ROUNDS(64), .STEPS(4)) dut1 (
    .CLK(clk), .RST(rst), .in_valid(iv[1]), .in_ready(ir[1]), .block_in(bus[511:0]),
    .w_valid(wv[1]), .w_ready(wr[1]), .w_out(wo1), .w_index(wi1), .w_last(wl[1]));
  sha2_w_expander_pipe #(.WORD_W(64), .ROUNDS(80), .STEPS(2)) dut2 (
    .CLK(clk), .RST(rst), .in_valid(iv[2]), .in_ready(ir[2]), .block_in(bus),
    .w_valid(wv[2]), .w_ready(wr[2]), .w_out(wo2), .w_index(wi2), .w_last(wl[2]));

  function automatic logic [255:0] get_wo(input int d);
    if (d == 0) return {224'b0, wo0};
    if (d == 1) return {128'b0, wo1};
    return {128'b0, wo2};
  endfunction

  function automatic logic [6:0] get_wi(input int d);
    if (d == 0) return wi0;
    if (d == 1) return wi1;
    return wi2;
  endfunction

  function automatic logic [63:0] word_at(input int d, input int k);
    logic [255:0] v;
    v = get_wo(d) >> ((NS[d] - 1 - k) * NW[d]);
    return (NW[d] == 32) ? {32'b0, v[31:0]} : v[63:0];
  endfunction

  // Reference schedule: rotations done on w-bit quantities, sums masked to w bits.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [31:0] a;
    if (w == 32) begin
      a = x[31:0];
      a = (a >> n) | (a << (32 - n));
      return {32'b0, a};
    end
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3);
    return rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10);
    return rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6);
  endfunction

  task automatic model(input int w, input int r, input blk_t b, output sch_t s);
    logic [63:0] m;
    m = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    for (int j = 0; j < 80; j++) begin
      if (j < 16)     s[j] = b[j] & m;
      else if (j < r) s[j] = (sig1(s[j-2], w) + s[j-7] + sig0(s[j-15], w) + s[j-16]) & m;
      else            s[j] = '0;
    end
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic put_block(input int d, input blk_t b);
    bus = '0;
    for (int i = 0; i < 16; i++) begin
      if (NW[d] == 32) bus[(15-i)*32 +: 32] = b[i][31:0];
      else             bus[(15-i)*64 +: 64] = b[i];
    end
  endtask

  task automatic rand_blk(input int d, output blk_t b);
    for (int i = 0; i < 16; i++) begin
      b[i] = {$urandom, $urandom};
      if (NW[d] == 32) b[i][63:32] = '0;
    end
  endtask

  // Streams one block; with stall set, w_ready toggles randomly and held beats must not move.
  task automatic run_block(input int d, input blk_t b, input bit stall, input string tag);
    sch_t         exp;
    int           t, cyc;
    bit           r, prev_stall;
    logic [255:0] snap_o;
    logic [6:0]   snap_i;
    logic         snap_l;
    model(NW[d], NR[d], b, exp);
    @(negedge clk);
    chk($sformatf("%s_idle_ready", tag), ir[d], 1);
    chk($sformatf("%s_idle_valid", tag), wv[d], 0);
    put_block(d, b);
    iv[d] = 1'b1;
    @(negedge clk);
    iv[d] = 1'b0;
    t = 0; cyc = 0; prev_stall = 0;
    while (t < NR[d]) begin
      if (cyc > 1000) begin
        chk($sformatf("%s_timeout_t", tag), t, NR[d]);
        break;
      end
      if (prev_stall) begin
        chk($sformatf("%s_hold_out", tag), get_wo(d), snap_o);
        chk($sformatf("%s_hold_idx", tag), get_wi(d), snap_i);
        chk($sformatf("%s_hold_last", tag), wl[d], snap_l);
      end
      chk($sformatf("%s_valid_t%0d", tag, t), wv[d], 1);
      chk($sformatf("%s_in_ready_t%0d", tag, t), ir[d], 0);
      chk($sformatf("%s_index_t%0d", tag, t), get_wi(d), t);
      chk($sformatf("%s_last_t%0d", tag, t), wl[d], (t == NR[d] - NS[d]));
      for (int k = 0; k < NS[d]; k++)
        chk($sformatf("%s_word_W%0d", tag, t + k), word_at(d, k), exp[t+k]);
      r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wr[d] = r;
      if (r) begin
        for (int k = 0; k < NS[d]; k++) got[d][t+k] = word_at(d, k);
        t += NS[d];
      end
      snap_o = get_wo(d); snap_i = get_wi(d); snap_l = wl[d];
      prev_stall = !r;
      @(negedge clk);
      cyc++;
    end
    wr[d] = 1'b0;
    chk($sformatf("%s_end_valid", tag), wv[d], 0);
    chk($sformatf("%s_end_ready", tag), ir[d], 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t a256, a512, ba, bb;
    sch_t ea, eb;
    vec_t tbl [8];
    int   p, gap, cyc;

    tbl[0] = '{0, 0,  64'h61626380};
    tbl[1] = '{0, 15, 64'h00000018};
    tbl[2] = '{0, 16, 64'h61626380};
    tbl[3] = '{0, 17, 64'h000F0000};
    tbl[4] = '{1, 16, 64'h61626380};
    tbl[5] = '{1, 17, 64'h000F0000};
    tbl[6] = '{2, 16, 64'h6162638000000000};
    tbl[7] = '{2, 17, 64'h00030000000000C0};

    for (int i = 0; i < 16; i++) begin a256[i] = '0; a512[i] = '0; end
    a256[0] = 64'h61626380;          a256[15] = 64'h18;
    a512[0] = 64'h6162638000000000;  a512[15] = 64'h18;

    rst = 1'b1; iv = '0; wr = '0; bus = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ready_%0d", d), ir[d], 0);
      chk($sformatf("rst_valid_%0d", d), wv[d], 0);
      chk($sformatf("rst_last_%0d", d), wl[d], 0);
      chk($sformatf("rst_out_%0d", d), get_wo(d), 0);
      chk($sformatf("rst_index_%0d", d), get_wi(d), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("post_rst_ready_%0d", d), ir[d], 1);

    run_block(0, a256, 0, "abc256_s1");
    run_block(1, a256, 0, "abc256_s4");
    run_block(2, a512, 0, "abc512_s2");
    for (int i = 0; i < 8; i++)
      chk($sformatf("known_d%0d_W%0d", tbl[i].d, tbl[i].idx), got[tbl[i].d][tbl[i].idx], tbl[i].val);

    run_block(0, a256, 1, "abc256_stall");
    for (int n = 0; n < 2; n++) begin
      for (int d = 0; d < 3; d++) begin
        rand_blk(d, ba);
        run_block(d, ba, 1'(n), $sformatf("rand_d%0d_n%0d", d, n));
      end
    end

    // Reset in the middle of a block, at index 20
    put_block(0, a256);
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0; wr[0] = 1'b1;
    cyc = 0;
    while (get_wi(0) != 7'd20 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("midrst_reach_20", get_wi(0), 20);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", wv[0], 0);
    chk("midrst_ready", ir[0], 0);
    chk("midrst_index", get_wi(0), 0);
    chk("midrst_out", get_wo(0), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", ir[0], 1);
    repeat (3) @(negedge clk);
    chk("midrst_no_beats", wv[0], 0);
    wr[0] = 1'b0;
    rand_blk(0, ba);
    run_block(0, ba, 0, "midrst_restart");

    // in_valid held across two blocks: exactly one bubble, second block from t=0
    rand_blk(1, ba); rand_blk(1, bb);
    model(32, 64, ba, ea); model(32, 64, bb, eb);
    @(negedge clk);
    put_block(1, ba);
    iv[1] = 1'b1;
    @(negedge clk);
    put_block(1, bb);
    wr[1] = 1'b1;
    p = 0; gap = 0; cyc = 0;
    while (p < 32 && cyc < 200) begin
      if (wv[1]) begin
        if (p == 16) begin
          chk("b2b_bubble", gap, 1);
          iv[1] = 1'b0;
        end
        chk($sformatf("b2b_in_ready_p%0d", p), ir[1], 0);
        chk($sformatf("b2b_index_p%0d", p), get_wi(1), (p % 16) * 4);
        for (int k = 0; k < 4; k++)
          chk($sformatf("b2b_word_p%0d_k%0d", p, k), word_at(1, k),
              (p < 16) ? ea[(p % 16) * 4 + k] : eb[(p % 16) * 4 + k]);
        p++;
        gap = 0;
      end else begin
        gap++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b_beats", p, 32);
    wr[1] = 1'b0; iv[1] = 1'b0;
    chk("b2b_end_valid", wv[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
